// File: rtl/adc_sample_capture_if.sv
// ADC serial bus plus sample output stream of the ADC capture block.
interface adc_sample_capture_if #(
  parameter int sample_width = 12
);
  logic                    adc_cs_n;
  logic                    adc_sclk;
  logic                    adc_sdata;
  logic [sample_width-1:0] sample;
  logic                    sample_valid;
  logic                    sample_ready;
  logic                    overrun;

  modport master (
    output adc_cs_n, adc_sclk, sample, sample_valid, overrun,
    input  adc_sdata, sample_ready
  );

  modport slave (
    input  adc_cs_n, adc_sclk, sample, sample_valid, overrun,
    output adc_sdata, sample_ready
  );
endinterface

// File: rtl/adc_sample_capture.sv
// Serial ADC front-end master: frames a 3-wire ADC once per sample period,
// deserialises the code, converts to two's complement, and hands the sample
// downstream with valid/ready and a sticky overrun flag.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// st_idle   | cs_n high, sclk high, wait for period counter wrap
// st_setup  | cs_n low, sclk high, chip-select setup time
// st_shift  | sclk toggles, one bit captured per sclk rising edge
// st_done   | cs_n high, sample register just loaded
module adc_sample_capture #(
  parameter int sample_width  = 12,
  parameter int lead_bits     = 4,
  parameter int clk_div       = 4,
  parameter int sample_period = 1024,
  parameter bit offset_binary = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  adc_sample_capture_if.master bus
);

  localparam int frame_bits = lead_bits + sample_width;
  localparam int dw = (clk_div > 1) ? $clog2(clk_div) : 1;
  localparam int bw = (frame_bits > 1) ? $clog2(frame_bits) : 1;
  localparam int pw = (sample_period > 1) ? $clog2(sample_period) : 1;
  localparam logic [dw-1:0] div_max = dw'(clk_div - 1);
  localparam logic [bw-1:0] bit_max = bw'(frame_bits - 1);
  localparam logic [pw-1:0] p_max   = pw'(sample_period - 1);
  localparam logic [sample_width-1:0] msb_flip =
    {offset_binary, {(sample_width-1){1'b0}}};

  generate
    if (clk_div < 1) begin : g_bad_div
      $error("adc_sample_capture: clk_div must be >= 1");
    end
    if (sample_period < clk_div * (2 + 2 * frame_bits) + 2) begin : g_bad_period
      $error("adc_sample_capture: sample_period too short for one frame");
    end
    if (sample_width < 2) begin : g_bad_width
      $error("adc_sample_capture: sample_width must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_setup = 2'd1,
    st_shift = 2'd2,
    st_done  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [dw-1:0]           div_q, div_d;
  logic [bw-1:0]           bit_q, bit_d;
  logic [pw-1:0]           p_q;
  logic                    sclk_q, sclk_d;
  logic                    cs_n_q, cs_n_d;
  logic                    shift_en, load;
  logic [sample_width-1:0] shreg_q;
  logic [sample_width-1:0] sample_q;
  logic                    valid_q;
  logic                    overrun_q;

  // Period counter: free-runs while enabled, parked at zero otherwise.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      p_q <= '0;
    end else if (p_q == p_max) begin
      p_q <= '0;
    end else begin
      p_q <= p_q + 1'b1;
    end
  end

  // FSM state, phase/bit down-counters and registered ADC pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= st_idle;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b1;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
    end
  end

  // Next state, next pin levels and capture/load strobes.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    shift_en = 1'b0;
    load     = 1'b0;
    case (state_q)
      st_idle: begin
        sclk_d = 1'b1;
        if (p_q == '0) begin
          state_d = st_setup;
          div_d   = div_max;
        end
      end
      st_setup: begin
        if (div_q == '0) begin
          state_d = st_shift;
          sclk_d  = 1'b0;
          div_d   = div_max;
          bit_d   = bit_max;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      st_shift: begin
        if (div_q != '0) begin
          div_d = div_q - 1'b1;
        end else if (!sclk_q) begin
          // end of low phase: sclk rises and the data bit is taken
          sclk_d   = 1'b1;
          shift_en = 1'b1;
          div_d    = div_max;
        end else if (bit_q == '0) begin
          state_d = st_done;
          load    = 1'b1;
        end else begin
          bit_d  = bit_q - 1'b1;
          sclk_d = 1'b0;
          div_d  = div_max;
        end
      end
      st_done: begin
        state_d = st_idle;
      end
      default: begin
        state_d = st_idle;
        sclk_d  = 1'b1;
      end
    endcase
    // Disable drops any frame in flight on the next edge.
    if (!enable) begin
      state_d  = st_idle;
      sclk_d   = 1'b1;
      shift_en = 1'b0;
      load     = 1'b0;
    end
    cs_n_d = !((state_d == st_setup) || (state_d == st_shift));
  end

  // Deserialiser; lead bits simply fall off the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
    end else if (shift_en) begin
      shreg_q <= {shreg_q[sample_width-2:0], bus.adc_sdata};
    end
  end

  // Output register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (load) begin
        sample_q <= shreg_q ^ msb_flip;
        valid_q  <= 1'b1;
        if (valid_q && !bus.sample_ready) begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && bus.sample_ready) begin
        valid_q <= 1'b0;
      end
      if (!enable) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.adc_cs_n     = cs_n_q;
  assign bus.adc_sclk     = sclk_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_adc_sample_capture.sv
// Directed bench for adc_sample_capture with a behavioural AD7476-style ADC.
module tb_adc_sample_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic ready = 1'b1;
  logic sdata = 1'b0;
  logic [15:0] word = 16'h0000;

  int n_assert = 0;
  int n_fail = 0;

  adc_sample_capture_if #(.sample_width(12)) bus0 ();
  adc_sample_capture_if #(.sample_width(12)) bus1 ();

  assign bus0.adc_sdata    = sdata;
  assign bus1.adc_sdata    = sdata;
  assign bus0.sample_ready = ready;
  assign bus1.sample_ready = ready;

  adc_sample_capture dut0 (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus0)
  );

  adc_sample_capture #(.offset_binary(1'b0)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus1)
  );

  always #5 clk = ~clk;

  // ADC model: new bit after each falling sclk, MSB first from cs_n fall.
  int idx = 15;
  always @(negedge bus0.adc_cs_n) idx = 15;
  always @(negedge bus0.adc_sclk) begin
    if (!bus0.adc_cs_n && idx >= 0) begin
      sdata = word[idx];
      idx = idx - 1;
    end
  end

  // Monitor: sampled 1 time unit after each rising clk edge.
  int cyc = 0;
  int fall_cnt = 0, last_fall = 0, prev_fall = 0;
  int valid_cnt = 0, last_valid = 0;
  int frame_rises = 0, last_rise = 0, rise_per = 0, stray = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_valid = 1'b0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (prev_cs && !bus0.adc_cs_n) begin
      prev_fall = last_fall;
      last_fall = cyc;
      fall_cnt = fall_cnt + 1;
      frame_rises = 0;
    end
    if (!prev_sclk && bus0.adc_sclk) begin
      if (prev_cs && bus0.adc_cs_n) stray = stray + 1;
      else begin
        if (frame_rises > 0) rise_per = cyc - last_rise;
        last_rise = cyc;
        frame_rises = frame_rises + 1;
      end
    end
    if (bus0.sample_valid && !prev_valid) begin
      valid_cnt = valid_cnt + 1;
      last_valid = cyc;
    end
    prev_cs = bus0.adc_cs_n;
    prev_sclk = bus0.adc_sclk;
    prev_valid = bus0.sample_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int start;
    logic ok;
    start = valid_cnt;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (valid_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_cs_fall(input string tag);
    int start;
    logic ok;
    start = fall_cnt;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (fall_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_rises(input int n, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (frame_rises == n) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cs_n"},    {31'd0, bus0.adc_cs_n},     32'd1);
    chk({tag, "_sclk"},    {31'd0, bus0.adc_sclk},     32'd1);
    chk({tag, "_sample"},  {20'd0, bus0.sample},       32'h000);
    chk({tag, "_valid"},   {31'd0, bus0.sample_valid}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, bus0.overrun},      32'd0);
  endtask

  int vsave;

  initial begin
    // Power-on reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");

    // Nominal frame: 4 zeros + 0xABC
    word = 16'h0ABC;
    rst = 1'b0;
    enable = 1'b1;
    wait_valid("nom_wait");
    chk("nom_sample", {20'd0, bus0.sample}, 32'h2BC);
    chk("nom_raw_ob0", {20'd0, bus1.sample}, 32'hABC);
    chk("nom_latency", last_valid - last_fall, 132);
    chk("nom_rises", frame_rises, 16);
    chk("nom_sclk_per", rise_per, 8);
    @(negedge clk);
    chk("nom_valid_1cyc", {31'd0, bus0.sample_valid}, 32'd0);

    // Code boundaries
    word = 16'h0000;
    wait_cs_fall("b0_fall");
    chk("frame_interval", last_fall - prev_fall, 1024);
    wait_valid("b0_wait");
    chk("b000_sample", {20'd0, bus0.sample}, 32'h800);
    chk("b000_ob0", {20'd0, bus1.sample}, 32'h000);
    word = 16'h0800;
    wait_valid("b8_wait");
    chk("b800_sample", {20'd0, bus0.sample}, 32'h000);
    word = 16'h0FFF;
    wait_valid("bf_wait");
    chk("bfff_sample", {20'd0, bus0.sample}, 32'h7FF);
    chk("bfff_ob0", {20'd0, bus1.sample}, 32'hFFF);
    chk("b_overrun", {31'd0, bus0.overrun}, 32'd0);
    @(negedge clk);

    // Backpressure over two frames
    ready = 1'b0;
    word = 16'h0111;
    wait_valid("bp1_wait");
    chk("bp1_sample", {20'd0, bus0.sample}, 32'h911);
    word = 16'h0222;
    repeat (500) @(negedge clk);
    chk("bp_hold_sample", {20'd0, bus0.sample}, 32'h911);
    chk("bp_hold_valid", {31'd0, bus0.sample_valid}, 32'd1);
    chk("bp_hold_overrun", {31'd0, bus0.overrun}, 32'd0);
    begin : bp2
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        @(negedge clk);
        if (bus0.sample !== 12'h911) begin
          ok = 1'b1;
          break;
        end
      end
      chk("bp2_wait", {31'd0, ok}, 32'd1);
    end
    chk("bp2_sample", {20'd0, bus0.sample}, 32'hA22);
    chk("bp2_valid", {31'd0, bus0.sample_valid}, 32'd1);
    chk("bp2_overrun", {31'd0, bus0.overrun}, 32'd1);
    ready = 1'b1;
    @(negedge clk);
    chk("bp_xfer_valid", {31'd0, bus0.sample_valid}, 32'd0);
    chk("bp_xfer_overrun", {31'd0, bus0.overrun}, 32'd1);

    // Abort at bit 7, then re-enable
    word = 16'h05A5;
    wait_cs_fall("ab_fall");
    wait_rises(7, "ab_rises");
    enable = 1'b0;
    vsave = valid_cnt;
    @(negedge clk);
    chk("ab_cs_n", {31'd0, bus0.adc_cs_n}, 32'd1);
    chk("ab_sclk", {31'd0, bus0.adc_sclk}, 32'd1);
    chk("ab_overrun", {31'd0, bus0.overrun}, 32'd0);
    repeat (200) @(negedge clk);
    chk("ab_no_valid", valid_cnt - vsave, 0);
    chk("ab_valid_low", {31'd0, bus0.sample_valid}, 32'd0);
    enable = 1'b1;
    wait_valid("re_wait");
    chk("re_sample", {20'd0, bus0.sample}, 32'hDA5);
    chk("re_rises", frame_rises, 16);
    chk("re_latency", last_valid - last_fall, 132);
    @(negedge clk);

    // Reset mid-frame at bit 10 with a pending sample
    ready = 1'b0;
    word = 16'h0333;
    wait_valid("rm_wait");
    chk("rm_pending", {20'd0, bus0.sample}, 32'hB33);
    word = 16'h0444;
    wait_cs_fall("rm_fall");
    wait_rises(10, "rm_rises");
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;
    wait_valid("post_wait");
    chk("post_sample", {20'd0, bus0.sample}, 32'hC44);
    chk("post_rises", frame_rises, 16);

    chk("no_stray_sclk", stray, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_sample_capture.md
Name: adc_sample_capture

Overview:
Serial ADC front-end master for the guitar input path. Drives a 3-wire ADC (CS_n/SCLK/SDATA, AD7476-style 16-clock frame with leading zeros) at a fixed sample rate. Deserialises each frame, converts offset-binary to two's complement, and presents a sample_width-bit signed sample with valid/ready. The output feeds directly into signed_expand for widening to the DSP word size.

Parameters:
sample_width, 12, ADC resolution; width of sample output.
lead_bits, 4, leading bits per frame, clocked in and discarded; frame_bits = lead_bits + sample_width.
clk_div, 4, clk cycles per SCLK half-period (>=1).
sample_period, 1024, clk cycles between frame starts; elaboration error if < clk_div*(2+2*frame_bits)+2.
offset_binary, 1, 1: invert MSB of raw code (offset-binary to two's complement); 0: pass raw.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable  in  1  run conversions; low aborts and idles
adc_cs_n  out  1  ADC chip select, active-low
adc_sclk  out  1  ADC serial clock, idle high
adc_sdata  in  1  ADC serial data, MSB first, stable around SCLK rising edge
sample  out  sample_width  two's-complement sample
sample_valid  out  1  sample holds a new value
sample_ready  in  1  downstream accepts sample
overrun  out  1  sticky: a sample was overwritten before acceptance

Behaviour:
- Reset (rst high at clk edge): adc_cs_n=1, adc_sclk=1, sample=0, sample_valid=0, overrun=0, period counter=0, FSM=IDLE. Reset overrides all, including mid-frame.
- Period counter p: 0..sample_period-1, wraps; increments only while enable=1, held at 0 when enable=0.
- FSM: IDLE -> SETUP -> SHIFT -> DONE -> IDLE.
  - IDLE: cs_n=1, sclk=1. Cycle T with enable=1 and p==0 -> SETUP.
  - SETUP: cs_n=0 from T+1, sclk=1, lasts clk_div cycles.
  - SHIFT: per bit, sclk low clk_div cycles, then high clk_div cycles. adc_sdata registered on the clk edge ending each low phase (SCLK rising). Shift register takes bits MSB first; bit counter 0..frame_bits-1.
  - DONE: at the edge ending the last high phase, cs_n=1 and the output register loads. This is cycle T+1+clk_div*(1+2*frame_bits); defaults: T+133. Return to IDLE.
- Conversion: raw = last sample_width bits shifted in; lead bits ignored. sample = raw ^ (offset_binary << (sample_width-1)).
- Handshake: transfer when sample_valid && sample_ready. sample_valid clears the cycle after transfer unless a new sample loads on the same edge; then it stays 1 with the new value. sample stays stable while valid && !ready.
- Overrun: a new sample loads while sample_valid=1 and sample_ready=0 -> sample overwritten, valid stays 1, overrun set. Overrun clears only on rst or enable=0.
- enable fall mid-frame: next edge cs_n=1, sclk=1, FSM=IDLE, p=0, partial frame discarded, no valid. A pending valid sample is retained. A new frame starts at the first cycle enable=1 (p==0).
- Exactly one frame per sample_period; adc_sclk shows exactly frame_bits rising edges per frame, none outside cs_n low.

Test Plan:
- Reset: rst 2 cycles during activity -> cs_n=1, sclk=1, sample=0x000, valid=0, overrun=0 next cycle.
- Nominal: defaults, ADC model sends 4 zeros + 0xABC, ready=1 -> 16 SCLK rising edges, 8-cycle SCLK period, valid one cycle at T+133 with sample=0x2BC, next cs_n fall at T+1025.
- Code boundaries: raw 0x000/0x800/0xFFF -> 0x800/0x000/0x7FF; offset_binary=0, raw 0xABC -> 0xABC.
- Backpressure: ready=0 over two frames (0x111 then 0x222) -> sample 0x911 held stable, then 0xA22; overrun=1. Ready=1 -> one transfer, valid drops, overrun stays 1.
- Abort: enable low at bit 7 -> cs_n/sclk high next cycle, no valid. Re-enable -> full frame from SETUP, correct sample.
- Reset mid-frame at bit 10 with valid pending -> all outputs at reset values, first post-reset frame correct.
